// File: rtl/definitions.sv
`default_nettype none
// ============================================================================
// Module      : definitions (package)
// Description : Shared definitions for the accumulator datapath.
//               - op_mne      : 4-bit opcode mnemonics
//               - pc_state_t  : program-counter controller states
//               - BR_TARGETS  : 16-entry jump target table, entry i = 16*i
// Revision    : 1.0  initial release
// ============================================================================
package definitions;

    typedef enum logic [3:0] {
        kADD = 4'd0,
        kSUB = 4'd1,
        kAND = 4'd2,
        kOR  = 4'd3,
        kXOR = 4'd4,
        kNOT = 4'd5,
        kSHL = 4'd6,
        kSHR = 4'd7,
        kLDI = 4'd8,
        kLD  = 4'd9,
        kST  = 4'd10,
        kNOP = 4'd11,
        kCLR = 4'd12,
        kJMP = 4'd13,
        kBRZ = 4'd14,
        kBRN = 4'd15
    } op_mne;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_t;

    // Jump targets. Every entry fits in 8 bits; the lookup zero-extends
    // to whatever PC width the controller is built with.
    localparam logic [7:0] BR_TARGETS [16] = '{
        8'd0,   8'd16,  8'd32,  8'd48,  8'd64,  8'd80,  8'd96,  8'd112,
        8'd128, 8'd144, 8'd160, 8'd176, 8'd192, 8'd208, 8'd224, 8'd240
    };

endpackage
`default_nettype wire

// File: rtl/br_lut.sv
`default_nettype none
// ============================================================================
// Module      : br_lut
// Description : Combinational jump-target lookup. Maps a 4-bit index to a
//               PC_W-bit instruction address taken from BR_TARGETS.
// Ports       : idx    in  4     table index (operand[3:0] of a JMP)
//               target out PC_W  zero-extended jump target
// Revision    : 1.0  initial release
// ============================================================================
module br_lut
    import definitions::*;
#(
    parameter int PC_W = 10
) (
    input  logic [3:0]      idx,
    output logic [PC_W-1:0] target
);

    assign target = PC_W'(BR_TARGETS[idx]);

endmodule
`default_nettype wire

// File: rtl/pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_ctrl
// Description : Program counter and branch control. Registers ALU flags,
//               resolves JMP/BRZ/BRN against the registered flags and
//               sequences one program per Start request (IDLE/RUN/DONE).
// Ports       : CLK, Reset          clock, synchronous active-high reset
//               Start               begin a run (IDLE/DONE only)
//               stall               hold current instruction (RUN only)
//               op, operand         instruction at pc and its branch field
//               flag_we, co, z, neg ALU flag capture enable and flag inputs
//               pc                  current instruction address
//               co_q, z_q, neg_q    registered flags
//               br_taken            high the cycle after a taken branch
//               Done                high while in DONE
// Revision    : 1.0  initial release
// ============================================================================
module pc_ctrl
    import definitions::*;
#(
    parameter int PC_W     = 10,
    parameter int PROG_END = 255
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            Start,
    input  logic            stall,
    input  logic [3:0]      op,
    input  logic [7:0]      operand,
    input  logic            flag_we,
    input  logic            co,
    input  logic            z,
    input  logic            neg,
    output logic [PC_W-1:0] pc,
    output logic            co_q,
    output logic            z_q,
    output logic            neg_q,
    output logic            br_taken,
    output logic            Done
);

    localparam logic [1:0] c_IDLE = IDLE;
    localparam logic [1:0] c_RUN  = RUN;
    localparam logic [1:0] c_DONE = DONE;

    logic [1:0]      r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_co;
    logic            r_z;
    logic            r_neg;
    logic            r_br_taken;

    logic [PC_W-1:0] w_lut_target;
    logic [PC_W-1:0] w_offset;
    logic [PC_W-1:0] w_seq_pc;
    logic [PC_W-1:0] w_rel_pc;
    logic [PC_W-1:0] w_next_pc;
    logic            w_take;
    logic            w_at_end;

    br_lut #(
        .PC_W   (PC_W)
    ) u_br_lut (
        .idx    (operand[3:0]),
        .target (w_lut_target)
    );

    // Sign-extend the 8-bit offset; the add then wraps modulo 2^PC_W.
    assign w_offset = PC_W'($signed(operand));
    assign w_seq_pc = r_pc + PC_W'(1);
    assign w_rel_pc = r_pc + w_offset;
    assign w_at_end = (r_pc == PC_W'(PROG_END));

    // Branch conditions use the registered flags, never the live ALU flags.
    always_comb begin
        w_next_pc = w_seq_pc;
        w_take    = 1'b0;
        case (op)
            kJMP: begin
                w_next_pc = w_lut_target;
                w_take    = 1'b1;
            end
            kBRZ: begin
                if (r_z) begin
                    w_next_pc = w_rel_pc;
                    w_take    = 1'b1;
                end
            end
            kBRN: begin
                if (r_neg) begin
                    w_next_pc = w_rel_pc;
                    w_take    = 1'b1;
                end
            end
            default: begin
                w_next_pc = w_seq_pc;
                w_take    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state    <= c_IDLE;
            r_pc       <= '0;
            r_co       <= 1'b0;
            r_z        <= 1'b0;
            r_neg      <= 1'b0;
            r_br_taken <= 1'b0;
        end else begin
            r_br_taken <= 1'b0;
            case (r_state)
                c_RUN: begin
                    if (!stall) begin
                        if (flag_we) begin
                            r_co  <= co;
                            r_z   <= z;
                            r_neg <= neg;
                        end
                        // The last instruction ends the run; any branch
                        // encoded there is discarded and pc stays put.
                        if (w_at_end) begin
                            r_state <= c_DONE;
                        end else begin
                            r_pc       <= w_next_pc;
                            r_br_taken <= w_take;
                        end
                    end
                end
                c_IDLE, c_DONE: begin
                    if (Start) begin
                        r_state <= c_RUN;
                        r_pc    <= '0;
                        r_co    <= 1'b0;
                        r_z     <= 1'b0;
                        r_neg   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign pc       = r_pc;
    assign co_q     = r_co;
    assign z_q      = r_z;
    assign neg_q    = r_neg;
    assign br_taken = r_br_taken;
    assign Done     = (r_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_ctrl
// Description : Self-checking bench for pc_ctrl (PC_W=10, PROG_END=5).
//               A driver applies one directed vector per cycle and queues
//               the hand-computed state expected after the next edge; a
//               monitor pops and compares after every rising edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pc_ctrl;
    import definitions::*;

    localparam int PC_W = 10;

    typedef struct {
        string           name;
        logic [PC_W-1:0] pc;
        logic            done;
        logic            co;
        logic            z;
        logic            neg;
        logic            br;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset, start, stall, flag_we, co, z, neg;
    logic [3:0]      op;
    logic [7:0]      operand;
    logic [PC_W-1:0] pc;
    logic            co_q, z_q, neg_q, br_taken, done;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   drv_done = 1'b0;

    pc_ctrl #(
        .PC_W     (PC_W),
        .PROG_END (5)
    ) dut (
        .CLK      (clk),
        .Reset    (reset),
        .Start    (start),
        .stall    (stall),
        .op       (op),
        .operand  (operand),
        .flag_we  (flag_we),
        .co       (co),
        .z        (z),
        .neg      (neg),
        .pc       (pc),
        .co_q     (co_q),
        .z_q      (z_q),
        .neg_q    (neg_q),
        .br_taken (br_taken),
        .Done     (done)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge and queue the state
    // expected right after the following rising edge.
    task automatic cyc(input string nm, input logic rst, input logic st,
                       input logic stl, input logic [3:0] o,
                       input logic [7:0] opd, input logic fwe,
                       input logic c, input logic zz, input logic n,
                       input logic [PC_W-1:0] e_pc, input logic e_done,
                       input logic e_co, input logic e_z, input logic e_neg,
                       input logic e_br);
        exp_t e;
        @(negedge clk);
        reset = rst; start = st; stall = stl; op = o; operand = opd;
        flag_we = fwe; co = c; z = zz; neg = n;
        e.name = nm; e.pc = e_pc; e.done = e_done; e.co = e_co;
        e.z = e_z; e.neg = e_neg; e.br = e_br;
        exp_q.push_back(e);
    endtask

    // Monitor
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if ({pc, done, co_q, z_q, neg_q, br_taken} ===
                {e.pc, e.done, e.co, e.z, e.neg, e.br}) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got pc=%0d done=%b co/z/neg=%b%b%b br=%b, expected pc=%0d done=%b co/z/neg=%b%b%b br=%b",
                         e.name, pc, done, co_q, z_q, neg_q, br_taken,
                         e.pc, e.done, e.co, e.z, e.neg, e.br);
            end
        end
    end

    // Driver
    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0; op = kADD; operand = 8'h00;
        flag_we = 1'b0; co = 1'b0; z = 1'b0; neg = 1'b0;

        //   name          rst st stl op    opnd   fwe co z  n   pc   dn co z  n  br
        cyc("reset0",      1, 0, 0, kADD, 8'h00, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
        cyc("reset1",      1, 0, 0, kADD, 8'h00, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc("idle",    0, 0, 0, kADD, 8'h00, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
        cyc("start",       0, 1, 0, kADD, 8'h00, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++)
            cyc("straight",0, 0, 0, kADD, 8'h00, 0, 0, 0, 0, 10'(i), 0, 0, 0, 0, 0);
        cyc("retire_end",  0, 0, 0, kADD, 8'h00, 0, 0, 0, 0,    5, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            cyc("done_hold",0, 0, 0, kADD, 8'h00, 0, 0, 0, 0,   5, 1, 0, 0, 0, 0);

        // Second run: BRZ taken/not taken, JMP, BRN wrap
        cyc("restart",     0, 1, 0, kADD, 8'h00, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
        cyc("flag_cz",     0, 0, 0, kADD, 8'h00, 1, 1, 1, 0,    1, 0, 1, 1, 0, 0);
        cyc("brz_fwd",     0, 0, 0, kBRZ, 8'h08, 0, 0, 0, 0,    9, 0, 1, 1, 0, 1);
        cyc("flag_z1",     0, 0, 0, kADD, 8'h00, 1, 0, 1, 0,   10, 0, 0, 1, 0, 0);
        cyc("brz_back",    0, 0, 0, kBRZ, 8'hFC, 0, 0, 0, 0,    6, 0, 0, 1, 0, 1);
        cyc("flag_z0",     0, 0, 0, kADD, 8'h00, 1, 0, 0, 0,    7, 0, 0, 0, 0, 0);
        cyc("start_in_run",0, 1, 0, kADD, 8'h00, 0, 0, 0, 0,    8, 0, 0, 0, 0, 0);
        cyc("seq9",        0, 0, 0, kADD, 8'h00, 0, 0, 0, 0,    9, 0, 0, 0, 0, 0);
        cyc("flag_z0b",    0, 0, 0, kADD, 8'h00, 1, 0, 0, 0,   10, 0, 0, 0, 0, 0);
        cyc("brz_nt",      0, 0, 0, kBRZ, 8'hFC, 0, 0, 0, 0,   11, 0, 0, 0, 0, 0);
        cyc("jmp3",        0, 0, 0, kJMP, 8'h03, 0, 0, 0, 0,   48, 0, 0, 0, 0, 1);
        cyc("flag_n1",     0, 0, 0, kADD, 8'h00, 1, 0, 0, 1,   49, 0, 0, 0, 1, 0);
        cyc("jmp0",        0, 0, 0, kJMP, 8'hF0, 0, 0, 0, 0,    0, 0, 0, 0, 1, 1);
        cyc("brn_wrap_lo", 0, 0, 0, kBRN, 8'hFD, 0, 0, 0, 0, 1021, 0, 0, 0, 1, 1);
        // Branch uses old neg_q=1 while the same retire clears it
        cyc("brn_wrap_hi", 0, 0, 0, kBRN, 8'h05, 1, 0, 0, 0,    2, 0, 0, 0, 0, 1);
        cyc("seq3",        0, 0, 0, kADD, 8'h00, 0, 0, 0, 0,    3, 0, 0, 0, 0, 0);
        cyc("seq4",        0, 0, 0, kADD, 8'h00, 0, 0, 0, 0,    4, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc("stall",   0, 0, 1, kJMP, 8'h03, 1, 0, 0, 1,    4, 0, 0, 0, 0, 0);
        cyc("unstall",     0, 0, 0, kADD, 8'h00, 1, 0, 0, 1,    5, 0, 0, 0, 1, 0);
        cyc("end_jmp_ign", 0, 0, 0, kJMP, 8'h03, 0, 0, 0, 0,    5, 1, 0, 0, 1, 0);
        cyc("done_flags",  0, 0, 0, kJMP, 8'h03, 1, 1, 1, 0,    5, 1, 0, 0, 1, 0);

        // Third run: reset mid-run together with Start
        cyc("restart2",    0, 1, 0, kADD, 8'h00, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
        cyc("flag_z1c",    0, 0, 0, kADD, 8'h00, 1, 0, 1, 0,    1, 0, 0, 1, 0, 0);
        cyc("brz_to7",     0, 0, 0, kBRZ, 8'h06, 0, 0, 0, 0,    7, 0, 0, 1, 0, 1);
        cyc("reset_start", 1, 1, 0, kJMP, 8'h03, 1, 1, 1, 1,    0, 0, 0, 0, 0, 0);
        cyc("idle_after",  0, 0, 0, kADD, 8'h00, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);

        // Fourth run: taken branch with offset 0 stays put
        cyc("restart3",    0, 1, 0, kADD, 8'h00, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
        cyc("flag_z1d",    0, 0, 0, kADD, 8'h00, 1, 0, 1, 0,    1, 0, 0, 1, 0, 0);
        cyc("brz_self",    0, 0, 0, kBRZ, 8'h00, 0, 0, 0, 0,    1, 0, 0, 1, 0, 1);
        cyc("seq2",        0, 0, 0, kADD, 8'h00, 0, 0, 0, 0,    2, 0, 0, 1, 0, 0);

        repeat (3) @(negedge clk);
        drv_done = 1'b1;
    end

    // Summary and bounded run time
    initial begin
        fork
            wait (drv_done);
            #100000;
        join_any
        disable fork;
        if (!drv_done) begin
            n_checks++;
            $display("FAIL timeout: driver did not finish, expected completion");
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL leftover: %0d expectations unchecked, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
